// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared constants for the router switch-allocation path: port count, virtual
// channels per port, downstream credit depth, field widths and the output
// port numbering used on req_port / xbar_sel.
// Ports: none (package).
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int NOC_NUM_PORTS    = 5;
  localparam int NOC_NUM_VCS      = 2;
  localparam int NOC_CREDIT_DEPTH = 4;

  // Field widths of the packed per-port buses.
  localparam int NOC_PORT_W = 3;   // req_port / xbar_sel slice width
  localparam int NOC_VC_W   = 2;   // req_vc / xbar_vc slice width
  localparam int NOC_CRED_W = 3;   // credit counter width, holds 0..CREDIT_DEPTH

  // Router port numbering.
  typedef enum logic [NOC_PORT_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_N     = 3'd1,
    PORT_E     = 3'd2,
    PORT_S     = 3'd3,
    PORT_W     = 3'd4
  } port_e;

  // Bit position of (output, vc) on credit_ret / credit_avail.
  function automatic int credit_bit(input int port, input int vc);
    return port * NOC_NUM_VCS + vc;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for one output port. The search for a winner starts at
// the input just after the last winner, so every requester is served within N
// grants. The pointer only moves when the owner says a grant was used.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; pointer -> N-1 (input 0 first)
//   i_req        [N]   request vector
//   i_update_en  1     load pointer with this cycle's winner
//   o_grant      [N]   one-hot grant (zero when nothing requests)
//   o_grant_idx  [IDX_W] binary index of the winner (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_update_en,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Walk the inputs in order ptr+1, ptr+2, ... wrapping at N; first request wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the loop can leave it unassigned and infer a latch.
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = (int'(r_ptr) + k >= N) ? IDX_W'(int'(r_ptr) + k - N)
                                      : IDX_W'(int'(r_ptr) + k);
      if (!w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
        w_found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (i_update_en) begin
      r_ptr <= o_grant_idx;
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// -----------------------------------------------------------------------------
// switch_allocator
// Separable switch allocator with credit-based flow control. Each input
// presents one head flit (target output + VC). A request is eligible when it is
// well formed and the downstream (output, VC) has credit. One round-robin
// arbiter per output picks a winner combinationally; the grant goes straight
// back to the input buffer, which dequeues on the same edge. The crossbar
// control is registered one cycle later (switch traversal stage).
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset; also blocks grants while high
//   req           [P]      per-input request
//   req_port      [3P]     per-input requested output, 3 bits each
//   req_vc        [2P]     per-input VC of the head flit, 2 bits each
//   grant         [P]      per-input grant (combinational)
//   xbar_sel      [3P]     per-output selected input, registered
//   xbar_valid    [P]      per-output traversal strobe, registered
//   xbar_vc       [2P]     per-output VC of the traversing flit, registered
//   credit_ret    [2P]     credit return pulse, bit 2o+v
//   credit_avail  [2P]     credit count for (o, v) nonzero, bit 2o+v
//   credit_err    1        sticky: credit returned into a full counter
// -----------------------------------------------------------------------------
module switch_allocator
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = NOC_NUM_PORTS,
  parameter int CREDIT_DEPTH = NOC_CREDIT_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NOC_PORT_W*NUM_PORTS-1:0]   req_port,
  input  logic [NOC_VC_W*NUM_PORTS-1:0]     req_vc,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [NOC_PORT_W*NUM_PORTS-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]              xbar_valid,
  output logic [NOC_VC_W*NUM_PORTS-1:0]     xbar_vc,
  input  logic [NOC_NUM_VCS*NUM_PORTS-1:0]  credit_ret,
  output logic [NOC_NUM_VCS*NUM_PORTS-1:0]  credit_avail,
  output logic                              credit_err
);

  localparam int NV = NOC_NUM_VCS;
  localparam int PW = NOC_PORT_W;
  localparam int VW = NOC_VC_W;
  localparam int CW = NOC_CRED_W;

  localparam logic [PW-1:0] PORT_LIMIT = PW'(NUM_PORTS);
  localparam logic [VW-1:0] VC_LIMIT   = VW'(NV);
  localparam logic [CW-1:0] CRED_FULL  = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0] CRED_ONE   = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_credit     [NUM_PORTS][NV];
  logic          r_credit_err;
  logic          r_xbar_valid [NUM_PORTS];
  logic [PW-1:0] r_xbar_sel   [NUM_PORTS];
  logic [VW-1:0] r_xbar_vc    [NUM_PORTS];

  // ---------------------------------------------------------------------------
  // Per-input decode and eligibility
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        w_in_port [NUM_PORTS];
  logic [VW-1:0]        w_in_vc   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_fmt_ok;
  logic [NUM_PORTS-1:0] w_elig;

  // Arbitration fabric: w_arb_req[o][i] = input i asks for output o.
  // w_gnt_t is the transpose of the arbiter grants, indexed by input.
  logic [NUM_PORTS-1:0] w_arb_req   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_arb_gnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_gnt_t     [NUM_PORTS];
  logic [PW-1:0]        w_sel_idx   [NUM_PORTS];
  logic [VW-1:0]        w_sel_vc    [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_out_valid;
  logic [NV*NUM_PORTS-1:0] w_overflow;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    assign w_in_port[i] = req_port[i*PW +: PW];
    assign w_in_vc[i]   = req_vc[i*VW +: VW];

    // Malformed port or VC fields are dropped here, before they can index
    // the credit table or reach an arbiter.
    assign w_fmt_ok[i] = req[i] && (w_in_port[i] < PORT_LIMIT) &&
                         (w_in_vc[i] < VC_LIMIT);

    // Credit is sampled from the registered counters only, so a return
    // arriving this cycle cannot enable a grant until the next cycle.
    // Holding rst suppresses every grant.
    assign w_elig[i] = !rst && w_fmt_ok[i] &&
                       (r_credit[w_in_port[i]][w_in_vc[i][0]] != '0);

    // Each input names a single output, so OR-ing across outputs still
    // yields at most one grant per input.
    assign grant[i] = |w_gnt_t[i];
  end

  // ---------------------------------------------------------------------------
  // Per-output arbitration, credit counters and traversal registers
  // ---------------------------------------------------------------------------
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
      assign w_arb_req[o][i] = w_elig[i] && (w_in_port[i] == PW'(o));
      assign w_gnt_t[i][o]   = w_arb_gnt[o][i];
    end

    rr_arbiter #(
      .N     (NUM_PORTS),
      .IDX_W (PW)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req       (w_arb_req[o]),
      .i_update_en (w_out_valid[o]),
      .o_grant     (w_arb_gnt[o]),
      .o_grant_idx (w_sel_idx[o])
    );

    assign w_out_valid[o] = |w_arb_gnt[o];
    assign w_sel_vc[o]    = w_in_vc[w_sel_idx[o]];

    for (genvar v = 0; v < NV; v++) begin : g_vc
      logic w_dec;
      logic w_ret;

      assign w_dec = w_out_valid[o] && (w_sel_vc[o] == VW'(v));
      assign w_ret = credit_ret[credit_bit(o, v)];

      // A grant and a return in the same cycle cancel. Only a return that
      // would push the count past the buffer depth is an error; a return
      // paired with a grant on a full counter is a legal slot hand-over.
      assign w_overflow[credit_bit(o, v)] = w_ret && !w_dec &&
                                            (r_credit[o][v] == CRED_FULL);

      always_ff @(posedge clk) begin
        // NOTE: the credit table is live flow-control state, not payload
        // storage, so every entry is reset to a known full count.
        if (rst) begin
          r_credit[o][v] <= CRED_FULL;
        end else if (w_dec && !w_ret) begin
          r_credit[o][v] <= r_credit[o][v] - CRED_ONE;
        end else if (w_ret && !w_dec && (r_credit[o][v] != CRED_FULL)) begin
          r_credit[o][v] <= r_credit[o][v] + CRED_ONE;
        end
      end

      assign credit_avail[credit_bit(o, v)] = (r_credit[o][v] != '0);
    end

    // Switch-traversal stage. Reset drops any in-flight traversal.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_xbar_valid[o] <= 1'b0;
        r_xbar_sel[o]   <= '0;
        r_xbar_vc[o]    <= '0;
      end else begin
        r_xbar_valid[o] <= w_out_valid[o];
        r_xbar_sel[o]   <= w_sel_idx[o];
        r_xbar_vc[o]    <= w_sel_vc[o];
      end
    end

    assign xbar_valid[o]         = r_xbar_valid[o];
    assign xbar_sel[o*PW +: PW]  = r_xbar_sel[o];
    assign xbar_vc[o*VW +: VW]   = r_xbar_vc[o];
  end

  // ---------------------------------------------------------------------------
  // Sticky overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit_err <= 1'b0;
    end else if (|w_overflow) begin
      r_credit_err <= 1'b1;
    end
  end

  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_switch_allocator.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator
// Directed scenarios plus a randomized run against a behavioural model of the
// allocator (credit table as integers, per-output "last winner" pointers).
// -----------------------------------------------------------------------------
module tb_switch_allocator;

  localparam int NP    = 5;
  localparam int NV    = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] req_port;
  logic [9:0]  req_vc;
  logic [4:0]  grant;
  logic [14:0] xbar_sel;
  logic [4:0]  xbar_valid;
  logic [9:0]  xbar_vc;
  logic [9:0]  credit_ret;
  logic [9:0]  credit_avail;
  logic        credit_err;

  always #5 clk = ~clk;

  switch_allocator #(
    .NUM_PORTS    (NP),
    .CREDIT_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_port     (req_port),
    .req_vc       (req_vc),
    .grant        (grant),
    .xbar_sel     (xbar_sel),
    .xbar_valid   (xbar_valid),
    .xbar_vc      (xbar_vc),
    .credit_ret   (credit_ret),
    .credit_avail (credit_avail),
    .credit_err   (credit_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_cred [NP][NV];
  int          m_ptr  [NP];
  bit          m_err;
  logic [4:0]  m_xv;
  logic [14:0] m_xs;
  logic [9:0]  m_xvc;
  int          e_src  [NP];   // winning input per output this cycle, -1 none
  logic [4:0]  e_grant;
  bit          e_rst;
  logic [9:0]  e_ret;

  // Observed values
  logic [4:0]  obs_grant;
  logic [4:0]  obs_xv;
  logic [14:0] obs_xs;
  logic [9:0]  obs_xvc;
  logic [9:0]  obs_ca;
  logic        obs_ce;

  function automatic int in_port(input int i);
    return int'(req_port[3*i +: 3]);
  endfunction

  function automatic int in_vc(input int i);
    return int'(req_vc[2*i +: 2]);
  endfunction

  function automatic bit m_elig(input int i);
    if (!req[i] || in_port(i) >= NP || in_vc(i) >= NV) return 1'b0;
    return m_cred[in_port(i)][in_vc(i)] > 0;
  endfunction

  function automatic logic [9:0] m_avail();
    logic [9:0] a;
    a = '0;
    for (int o = 0; o < NP; o++)
      for (int v = 0; v < NV; v++)
        a[2*o+v] = (m_cred[o][v] > 0);
    return a;
  endfunction

  // Pick a winner per output: first eligible input after the last winner.
  task automatic model_comb();
    e_rst   = rst;
    e_ret   = credit_ret;
    e_grant = '0;
    for (int o = 0; o < NP; o++) e_src[o] = -1;
    if (!e_rst) begin
      for (int o = 0; o < NP; o++) begin
        for (int k = 1; k <= NP; k++) begin
          int i;
          i = (m_ptr[o] + k) % NP;
          if (e_src[o] < 0 && m_elig(i) && in_port(i) == o) e_src[o] = i;
        end
        if (e_src[o] >= 0) e_grant[e_src[o]] = 1'b1;
      end
    end
  endtask

  task automatic model_update();
    if (e_rst) begin
      for (int o = 0; o < NP; o++) begin
        m_ptr[o] = NP - 1;
        for (int v = 0; v < NV; v++) m_cred[o][v] = DEPTH;
      end
      m_err = 1'b0;
      m_xv  = '0;
      m_xs  = '0;
      m_xvc = '0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        m_xv[o] = (e_src[o] >= 0);
        if (e_src[o] >= 0) begin
          m_xs[3*o +: 3]  = 3'(e_src[o]);
          m_xvc[2*o +: 2] = 2'(in_vc(e_src[o]));
          m_ptr[o]        = e_src[o];
        end
        for (int v = 0; v < NV; v++) begin
          int n;
          n = m_cred[o][v]
              - ((e_src[o] >= 0 && in_vc(e_src[o]) == v) ? 1 : 0)
              + (e_ret[2*o+v] ? 1 : 0);
          if (n > DEPTH) begin
            n     = DEPTH;
            m_err = 1'b1;
          end
          m_cred[o][v] = n;
        end
      end
    end
  endtask

  // One clock cycle: sample the combinational grant mid-cycle, advance the
  // model at the edge, sample registered outputs just after the edge.
  task automatic tick();
    #1;
    model_comb();
    obs_grant = grant;
    @(posedge clk);
    model_update();
    #1;
    obs_xv  = xbar_valid;
    obs_xs  = xbar_sel;
    obs_xvc = xbar_vc;
    obs_ca  = credit_avail;
    obs_ce  = credit_err;
  endtask

  task automatic set_idle();
    req        = '0;
    req_port   = '0;
    req_vc     = '0;
    credit_ret = '0;
  endtask

  task automatic set_req(input int i, input int p, input int v);
    req[i]             = 1'b1;
    req_port[3*i +: 3] = 3'(p);
    req_vc[2*i +: 2]   = 2'(v);
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    set_idle();
    set_req(0, 1, 0);
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_grant !== 5'b0) begin
      n_errors++; $display("FAIL reset_grant_forced got %b want 00000", obs_grant);
    end
    n_checks++;
    if (obs_ca !== 10'h3FF) begin
      n_errors++; $display("FAIL reset_credit_avail got %h want 3ff", obs_ca);
    end
    n_checks++;
    if (obs_xv !== 5'b0 || obs_xs !== 15'b0 || obs_xvc !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_xbar got valid=%b sel=%h vc=%h want all zero", obs_xv, obs_xs, obs_xvc);
    end
    n_checks++;
    if (obs_ce !== 1'b0) begin
      n_errors++; $display("FAIL reset_credit_err got %b want 0", obs_ce);
    end
    rst = 1'b0;
    set_idle();
    tick();
    n_checks++;
    if (obs_grant !== 5'b0 || obs_xv !== 5'b0) begin
      n_errors++; $display("FAIL reset_idle got grant=%b valid=%b want 0/0", obs_grant, obs_xv);
    end
  endtask

  task automatic test_contention();
    int seq [4] = '{1, 2, 3, 1};
    logic [4:0] want;
    do_reset();
    set_req(1, 2, 0);
    set_req(2, 2, 0);
    set_req(3, 2, 0);
    credit_ret[4] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      want = 5'b1 << seq[c];
      tick();
      n_checks++;
      if (obs_grant !== want) begin
        n_errors++; $display("FAIL contention_grant[%0d] got %b want %b", c, obs_grant, want);
      end
      n_checks++;
      if (obs_xv[2] !== 1'b1 || obs_xs[8:6] !== 3'(seq[c])) begin
        n_errors++;
        $display("FAIL contention_xbar[%0d] got valid=%b sel=%0d want 1/%0d", c, obs_xv[2], obs_xs[8:6], seq[c]);
      end
    end
    n_checks++;
    if (obs_ca[4] !== 1'b1 || obs_ce !== 1'b0) begin
      n_errors++; $display("FAIL contention_credit got avail=%b err=%b want 1/0", obs_ca[4], obs_ce);
    end
  endtask

  task automatic test_exhaustion();
    logic want;
    do_reset();
    set_req(0, 4, 1);
    for (int c = 0; c < 6; c++) begin
      want = (c < 4);
      tick();
      n_checks++;
      if (obs_grant[0] !== want) begin
        n_errors++; $display("FAIL exhaust_grant[%0d] got %b want %b", c, obs_grant[0], want);
      end
    end
    n_checks++;
    if (obs_ca !== 10'h1FF) begin
      n_errors++; $display("FAIL exhaust_avail got %h want 1ff", obs_ca);
    end
    credit_ret[9] = 1'b1;
    tick();
    n_checks++;
    if (obs_grant[0] !== 1'b0) begin
      n_errors++; $display("FAIL exhaust_same_cycle_return got %b want 0", obs_grant[0]);
    end
    credit_ret[9] = 1'b0;
    tick();
    n_checks++;
    if (obs_grant[0] !== 1'b1) begin
      n_errors++; $display("FAIL exhaust_regrant got %b want 1", obs_grant[0]);
    end
    n_checks++;
    if (obs_xv !== 5'b10000 || obs_xs[14:12] !== 3'd0 || obs_xvc[9:8] !== 2'd1 || obs_ca[9] !== 1'b0) begin
      n_errors++;
      $display("FAIL exhaust_regrant_xbar got valid=%b sel=%0d vc=%0d avail=%b want 10000/0/1/0",
               obs_xv, obs_xs[14:12], obs_xvc[9:8], obs_ca[9]);
    end
  endtask

  task automatic test_simultaneous();
    int g;
    do_reset();
    set_req(1, 1, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (obs_grant !== 5'b00010) begin
        n_errors++; $display("FAIL simul_prefill[%0d] got %b want 00010", c, obs_grant);
      end
    end
    // Counter (1,0) now 2; grant and return together must leave it at 2.
    credit_ret[2] = 1'b1;
    tick();
    credit_ret[2] = 1'b0;
    g = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      g += int'(obs_grant[1]);
    end
    n_checks++;
    if (g !== 2) begin
      n_errors++; $display("FAIL simul_count_unchanged got %0d grants want 2", g);
    end
    set_idle();
    credit_ret[2] = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    n_checks++;
    if (obs_ce !== 1'b0 || obs_ca[2] !== 1'b1) begin
      n_errors++; $display("FAIL simul_refill got err=%b avail=%b want 0/1", obs_ce, obs_ca[2]);
    end
    tick();
    n_checks++;
    if (obs_ce !== 1'b1) begin
      n_errors++; $display("FAIL simul_overflow_err got %b want 1", obs_ce);
    end
    credit_ret[2] = 1'b0;
    tick();
    n_checks++;
    if (obs_ce !== 1'b1) begin
      n_errors++; $display("FAIL simul_err_sticky got %b want 1", obs_ce);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    set_req(0, 1, 0);
    set_req(3, 4, 1);
    tick();
    n_checks++;
    if (obs_grant !== 5'b01001) begin
      n_errors++; $display("FAIL parallel_grant got %b want 01001", obs_grant);
    end
    n_checks++;
    if (obs_xv !== 5'b10010) begin
      n_errors++; $display("FAIL parallel_valid got %b want 10010", obs_xv);
    end
    n_checks++;
    if (obs_xs[5:3] !== 3'd0 || obs_xs[14:12] !== 3'd3 || obs_xvc[3:2] !== 2'd0 || obs_xvc[9:8] !== 2'd1) begin
      n_errors++;
      $display("FAIL parallel_sel got sel1=%0d sel4=%0d vc1=%0d vc4=%0d want 0/3/0/1",
               obs_xs[5:3], obs_xs[14:12], obs_xvc[3:2], obs_xvc[9:8]);
    end
  endtask

  task automatic test_bad_requests();
    int g;
    do_reset();
    set_req(2, 5, 0);
    set_req(4, 1, 2);
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (obs_grant !== 5'b0) begin
        n_errors++; $display("FAIL bad_req[%0d] got %b want 00000", c, obs_grant);
      end
      set_idle();
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 1) == 0) set_req(i, int'($urandom_range(5, 7)), int'($urandom_range(0, 3)));
        else                           set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(2, 3)));
      end
    end
    // Drain (3,0) to one credit, then assert reset while a grant is pending.
    set_idle();
    set_req(0, 3, 0);
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs_grant !== 5'b0) begin
      n_errors++; $display("FAIL bad_rst_grant got %b want 00000", obs_grant);
    end
    n_checks++;
    if (obs_ca !== 10'h3FF || obs_xv !== 5'b0) begin
      n_errors++; $display("FAIL bad_rst_state got avail=%h valid=%b want 3ff/00000", obs_ca, obs_xv);
    end
    rst = 1'b0;
    g = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      g += int'(obs_grant[0]);
    end
    n_checks++;
    if (g !== DEPTH) begin
      n_errors++; $display("FAIL bad_rst_counter_full got %0d grants want %0d", g, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [14:0] smask;
    logic [9:0]  vmask;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NP; i++) begin
        int p, v;
        p = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
        req_port[3*i +: 3] = 3'(p);
        req_vc[2*i +: 2]   = 2'(v);
        req[i]             = ($urandom_range(0, 2) != 0);
      end
      for (int b = 0; b < 2*NP; b++) credit_ret[b] = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (obs_grant !== e_grant) begin
        n_errors++; $display("FAIL rand_grant[%0d] got %b want %b", c, obs_grant, e_grant);
      end
      n_checks++;
      if (obs_ca !== m_avail() || obs_ce !== m_err) begin
        n_errors++;
        $display("FAIL rand_credit[%0d] got avail=%h err=%b want %h/%b", c, obs_ca, obs_ce, m_avail(), m_err);
      end
      smask = '0;
      vmask = '0;
      for (int o = 0; o < NP; o++) begin
        if (m_xv[o]) begin
          smask[3*o +: 3] = 3'b111;
          vmask[2*o +: 2] = 2'b11;
        end
      end
      n_checks++;
      if (obs_xv !== m_xv || (obs_xs & smask) !== (m_xs & smask) || (obs_xvc & vmask) !== (m_xvc & vmask)) begin
        n_errors++;
        $display("FAIL rand_xbar[%0d] got valid=%b sel=%h vc=%h want %b/%h/%h",
                 c, obs_xv, obs_xs & smask, obs_xvc & vmask, m_xv, m_xs & smask, m_xvc & vmask);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    for (int o = 0; o < NP; o++) begin
      m_ptr[o] = NP - 1;
      e_src[o] = -1;
      for (int v = 0; v < NV; v++) m_cred[o][v] = DEPTH;
    end
    m_err = 1'b0;
    m_xv  = '0;
    m_xs  = '0;
    m_xvc = '0;

    test_reset();
    test_contention();
    test_exhaustion();
    test_simultaneous();
    test_parallel();
    test_bad_requests();
    test_random();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5, meaning number of router input and output ports (0 local, 1 N, 2 E, 3 S, 4 W).
REQ-002 SHALL have parameter CREDIT_DEPTH, default 4, meaning downstream buffer slots per VC.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  5  per-input switch request, driven by each input buffer's cba_request.
REQ-006 SHALL have port req_port  input  15  per-input requested output port, 3 bits each; input i uses bits [3i+2:3i].
REQ-007 SHALL have port req_vc  input  10  per-input VC of the head flit, 2 bits each; input i uses bits [2i+1:2i].
REQ-008 SHALL have port grant  output  5  per-input grant, driving each input buffer's cba_grant.
REQ-009 SHALL have port xbar_sel  output  15  per-output selected input index, 3 bits each.
REQ-010 SHALL have port xbar_valid  output  5  per-output flag: a flit traverses the crossbar this cycle.
REQ-011 SHALL have port xbar_vc  output  10  per-output VC of the traversing flit, 2 bits each.
REQ-012 SHALL have port credit_ret  input  10  credit return pulse; bit 2o+v means output o, VC v freed one slot.
REQ-013 SHALL have port credit_avail  output  10  bit 2o+v high when credit count for output o, VC v is nonzero.
REQ-014 SHALL have port credit_err  output  1  sticky flag: a credit return arrived while the counter was already full.

Function
REQ-015 SHALL treat a request as eligible only when all hold: req[i]=1, req_port<NUM_PORTS, req_vc in {0,1}, and credit for (req_port, req_vc) >0.
REQ-016 SHALL never grant ineligible requests; malformed port or VC values are silently ignored.
REQ-017 SHALL arbitrate each output independently using round-robin among eligible inputs targeting it; search order starts at ptr+1 mod NUM_PORTS.
REQ-018 SHALL drive grant combinationally in the same cycle from req, req_port, req_vc and registered state (zero-cycle latency); the buffer dequeues on that edge.
REQ-019 SHALL grant at most one input per output per cycle; each input receives at most one grant.
REQ-020 SHALL update an output's pointer to the granted input index at the clock edge, and only when a grant occurs for that output.
REQ-021 SHALL register xbar_sel, xbar_vc and xbar_valid one cycle after the grant (switch-traversal stage); xbar_valid low means xbar_sel and xbar_vc are don't-care.
REQ-022 SHALL keep one credit counter per (output, VC), 3 bits wide, range 0..CREDIT_DEPTH.
REQ-023 SHALL decrement a credit counter by 1 on a grant for that (output, VC) and increment it by 1 on credit_ret.
REQ-024 SHALL leave a credit counter unchanged when a grant and a credit return for it occur in the same cycle.
REQ-025 SHALL hold a credit counter at CREDIT_DEPTH on a return when full, setting credit_err; it clears only on reset.
REQ-026 SHALL not let credit_ret in cycle N make a zero-credit request eligible before cycle N+1.
REQ-027 SHALL force grant to 0 in any cycle where rst is high.

Reset
REQ-028 SHALL, on a rising edge with rst high, set: all credit counters = CREDIT_DEPTH; all pointers = NUM_PORTS-1 (input 0 gets first priority); xbar_valid = 0; xbar_sel = 0; xbar_vc = 0; credit_err = 0.
REQ-029 SHALL, when reset asserts mid-operation, discard any in-flight traversal; no xbar_valid pulse appears in the cycle after reset.

Structure
REQ-030 SHALL take NUM_PORTS, NUM_VCS=2, CREDIT_DEPTH=4 and the port-index encoding from the shared package noc_pkg.
REQ-031 SHALL instantiate NUM_PORTS copies of one sub-module, rr_arbiter: 5-bit request in, one-hot grant out, registered pointer with an update-enable.

Verification
REQ-032 SHALL verify reset state: after reset, credit_avail=10'h3FF, grant=0, xbar_valid=0, credit_err=0.
REQ-033 SHALL verify contention: inputs 1, 2, 3 hold requests to port 2 on VC0, with credit_ret[4] pulsed every cycle; grants go to input 1, then 2, then 3, then 1, and xbar_sel[8:6] follows one cycle later.
REQ-034 SHALL verify credit exhaustion: input 0 requests port 4 on VC1 for 6 cycles with no returns; exactly 4 grants, credit_avail[9] drops to 0, and grant[0] stays low until credit_ret[9] pulses, then re-grants the next cycle.
REQ-035 SHALL verify simultaneous events: a grant and credit_ret on the same (output, VC) in one cycle leave the count unchanged; a return on a full counter sets credit_err=1.
REQ-036 SHALL verify parallel traffic: input 0 to port 1 and input 3 to port 4 in the same cycle are both granted, and xbar_valid=5'b10010 on the next cycle.
REQ-037 SHALL verify bad requests: req_port=5 or req_vc=2 is never granted; asserting rst during an active grant cycle forces grant=0 and all counters back to 4.
